// File: rtl/uart_pkg.sv
// uart_pkg: frame constants, FSM state encodings and parity decode shared by uart_tx and uart_rx.
// Latency: none, compile-time helpers and type definitions only.
// Backpressure: none.
package uart_pkg;

  // One-hot receiver/transmitter states; the *_IX constants index the hot bit.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_STOP  = 4'b1000
  } uart_state_e;

  localparam int ST_IDLE_IX  = 0;
  localparam int ST_START_IX = 1;
  localparam int ST_DATA_IX  = 2;
  localparam int ST_STOP_IX  = 3;

  typedef enum logic [2:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN,
    PAR_MARK,
    PAR_SPACE
  } parity_mode_e;

  // Clock cycles per bit on the line (integer division, truncates).
  function automatic int f_cntdiv(input int freq, input int baud);
    return freq / baud;
  endfunction

  // Parity parameter is an ASCII character: "N", "O", "E", "M" or "S".
  function automatic parity_mode_e f_parity_mode(input logic [7:0] p);
    case (p)
      "O":     return PAR_ODD;
      "E":     return PAR_EVEN;
      "M":     return PAR_MARK;
      "S":     return PAR_SPACE;
      default: return PAR_NONE;
    endcase
  endfunction

  // Bits shifted between start and stop: data plus the optional parity bit.
  function automatic int f_frame_bits(input int databits, input logic [7:0] parity);
    return databits + ((f_parity_mode(parity) != PAR_NONE) ? 1 : 0);
  endfunction

  // xor_all is the XOR over the data bits and the received parity bit.
  function automatic logic f_parity_err(input parity_mode_e mode,
                                        input logic         xor_all,
                                        input logic         pbit);
    case (mode)
      PAR_ODD:   return ~xor_all;
      PAR_EVEN:  return xor_all;
      PAR_MARK:  return ~pbit;
      PAR_SPACE: return pbit;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the serial line plus 1->0 fall detector.
// Latency: 2 clocks pad to O_rxd; O_fall is high in the first cycle O_rxd shows the new low level.
// Backpressure: none, free running.
//
// Ports:
//   I_clk   in   clock
//   I_rstn  in   asynchronous active-low reset
//   I_rxd   in   raw asynchronous serial line, idle high
//   O_rxd   out  synchronized line level
//   O_fall  out  one-cycle pulse on a synchronized high-to-low transition
module uart_rx_sync (
  input  logic I_clk,
  input  logic I_rstn,
  input  logic I_rxd,
  output logic O_rxd,
  output logic O_fall
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic [2:0] r_fill;

  // The flops reset to the idle level. r_fill tracks which stages already
  // hold real line samples, so the reset value of r_prev can never pair with
  // a line that is already low at release and fake a fall.
  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
      r_fill <= 3'b000;
    end else begin
      r_meta <= I_rxd;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_fill <= {r_fill[1:0], 1'b1};
    end
  end

  assign O_rxd  = r_sync;
  assign O_fall = r_fill[2] & r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, mid-bit sampling, parity and stop-bit checking.
// Latency: strobe 3 + HALF + (DATABITS+P+1)*CNTDIV + 1 clocks after the start-bit edge at the pad.
// Backpressure: none; O_valid is a one-cycle strobe and the host must take it when it appears.
//
// Ports:
//   I_clk         in   clock
//   I_rstn        in   asynchronous active-low reset
//   I_rxd         in   serial line, asynchronous, idle high
//   O_data        out  last received word, LSB = first data bit on the line
//   O_valid       out  one-cycle strobe, O_data and the error flags update with it
//   O_parity_err  out  parity mismatch on the last frame (always 0 with no parity)
//   O_frame_err   out  stop bit sampled low on the last frame
//   O_busy        out  high whenever the receiver is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int         FREQUENCY = 50000000,
  parameter int         BAUDRATE  = 9600,
  parameter int         DATABITS  = 8,
  parameter logic [7:0] PARITY    = "N",
  parameter real        STOPBITS  = 1.0
) (
  input  logic                I_clk,
  input  logic                I_rstn,
  input  logic                I_rxd,
  output logic [DATABITS-1:0] O_data,
  output logic                O_valid,
  output logic                O_parity_err,
  output logic                O_frame_err,
  output logic                O_busy
);

  localparam int           CNTDIV = f_cntdiv(FREQUENCY, BAUDRATE);
  localparam int           HALF   = CNTDIV / 2;
  localparam parity_mode_e PMODE  = f_parity_mode(PARITY);
  localparam int           NBITS  = f_frame_bits(DATABITS, PARITY);
  localparam int           CW     = $clog2(CNTDIV);

  localparam logic [CW-1:0] C_HALF     = CW'(HALF);
  localparam logic [CW-1:0] C_LAST     = CW'(CNTDIV - 1);
  localparam logic [3:0]    C_BIT_LAST = 4'(NBITS - 1);

  // Only the first stop bit is ever sampled; any further stop time is just
  // idle line, so STOPBITS affects nothing beyond this legality check.
  if (DATABITS < 5 || DATABITS > 9) begin : g_bad_databits
    $error("uart_rx: DATABITS must be in 5..9");
  end
  if (STOPBITS != 1.0 && STOPBITS != 1.5 && STOPBITS != 2.0) begin : g_bad_stopbits
    $error("uart_rx: STOPBITS must be 1.0, 1.5 or 2.0");
  end
  if (CNTDIV < 4) begin : g_bad_cntdiv
    $error("uart_rx: FREQUENCY/BAUDRATE must be at least 4");
  end

  logic w_rxd;
  logic w_fall;

  uart_rx_sync u_sync (
    .I_clk  (I_clk),
    .I_rstn (I_rstn),
    .I_rxd  (I_rxd),
    .O_rxd  (w_rxd),
    .O_fall (w_fall)
  );

  uart_state_e   r_state;
  uart_state_e   w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bitcnt;
  logic [NBITS-1:0] r_shift;

  logic w_cnt_clr;
  logic w_shift_en;
  logic w_stop_smp;
  logic w_par_err;

  logic [DATABITS-1:0] r_data;
  logic                r_valid;
  logic                r_perr;
  logic                r_ferr;

  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The counter is held at 0 in IDLE, so in START it has counted through
  // 0..HALF-1 when it reads HALF: that cycle is the mid-start-bit sample.
  // DATA and STOP restart from 0 and sample on the last count of each bit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_stop_smp  = 1'b0;
    unique case (1'b1)
      r_state[ST_IDLE_IX]: begin
        w_cnt_clr = 1'b1;
        if (w_fall) begin
          w_state_nxt = ST_START;
        end
      end
      r_state[ST_START_IX]: begin
        if (r_cnt == C_HALF) begin
          w_cnt_clr = 1'b1;
          // A high line at mid-start means a glitch, not a frame.
          w_state_nxt = w_rxd ? ST_IDLE : ST_DATA;
        end
      end
      r_state[ST_DATA_IX]: begin
        if (r_cnt == C_LAST) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bitcnt == C_BIT_LAST) begin
            w_state_nxt = ST_STOP;
          end
        end
      end
      r_state[ST_STOP_IX]: begin
        if (r_cnt == C_LAST) begin
          w_cnt_clr   = 1'b1;
          w_stop_smp  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The parity bit, when present, is the last bit shifted in and lands in the MSB.
  assign w_par_err = f_parity_err(PMODE, ^r_shift, r_shift[NBITS-1]);

  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      if (r_state[ST_IDLE_IX]) begin
        r_bitcnt <= '0;
      end else if (w_shift_en) begin
        r_bitcnt <= r_bitcnt + 1'b1;
      end
      // LSB-first line order: shift right, new bit enters at the top.
      if (w_shift_en) begin
        r_shift <= {w_rxd, r_shift[NBITS-1:1]};
      end
    end
  end

  // Frames with errors are still delivered; the flags hold until the next strobe.
  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= w_stop_smp;
      if (w_stop_smp) begin
        r_data <= r_shift[DATABITS-1:0];
        r_perr <= w_par_err;
        r_ferr <= ~w_rxd;
      end
    end
  end

  assign O_data       = r_data;
  assign O_valid      = r_valid;
  assign O_parity_err = r_perr;
  assign O_frame_err  = r_ferr;
  assign O_busy       = ~r_state[ST_IDLE_IX];

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives three receivers (8N1, 8E1, 8O2) with scripted and random frames.
// Latency: expected strobe cycle is derived from the frame timing rules.
// Backpressure: none.
module tb_uart_rx;

  localparam int CNTDIV = 16;
  localparam int HALF   = CNTDIV / 2;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd [3] = '{1'b1, 1'b1, 1'b1};
  logic [7:0] o_data [3];
  logic       o_valid [3];
  logic       o_perr [3];
  logic       o_ferr [3];
  logic       o_busy [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt [3] = '{0, 0, 0};

  typedef struct {
    int         dut;
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         cyc;
  } rec_t;

  rec_t mon_q [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (o_valid[i] === 1'b1) mon_q.push_back('{i, o_data[i], o_perr[i], o_ferr[i], cyc});
      if (o_busy[i] === 1'b1) busy_cnt[i] <= busy_cnt[i] + 1;
    end
  end

  uart_rx #(.FREQUENCY(1600000), .BAUDRATE(100000), .DATABITS(8), .PARITY("N"), .STOPBITS(1.0)) u_dut_n (
    .I_clk(clk), .I_rstn(rstn), .I_rxd(rxd[0]), .O_data(o_data[0]), .O_valid(o_valid[0]),
    .O_parity_err(o_perr[0]), .O_frame_err(o_ferr[0]), .O_busy(o_busy[0]));

  uart_rx #(.FREQUENCY(1600000), .BAUDRATE(100000), .DATABITS(8), .PARITY("E"), .STOPBITS(1.0)) u_dut_e (
    .I_clk(clk), .I_rstn(rstn), .I_rxd(rxd[1]), .O_data(o_data[1]), .O_valid(o_valid[1]),
    .O_parity_err(o_perr[1]), .O_frame_err(o_ferr[1]), .O_busy(o_busy[1]));

  uart_rx #(.FREQUENCY(1600000), .BAUDRATE(100000), .DATABITS(8), .PARITY("O"), .STOPBITS(2.0)) u_dut_o (
    .I_clk(clk), .I_rstn(rstn), .I_rxd(rxd[2]), .O_data(o_data[2]), .O_valid(o_valid[2]),
    .O_parity_err(o_perr[2]), .O_frame_err(o_ferr[2]), .O_busy(o_busy[2]));

  // ---------------- reference model ----------------
  // Parity bit a correct transmitter would send: even -> total ones even, odd -> total ones odd.
  function automatic logic good_parity(input int dut, input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (dut == 1) ? logic'(ones % 2) : logic'((ones + 1) % 2);
  endfunction

  function automatic int frame_bits(input int dut);
    return (dut == 0) ? 8 : 9;
  endfunction

  function automatic logic exp_perr(input int dut, input logic [7:0] d, input logic pbit);
    return (dut == 0) ? 1'b0 : (pbit != good_parity(dut, d));
  endfunction

  // Pad edge -> first busy cycle 3 clocks, +HALF to start sample, +(bits+1) bit times
  // to the stop sample, +1 for the strobe.
  function automatic int exp_cyc(input int dut, input int t_start);
    return t_start + 3 + HALF + (frame_bits(dut) + 1) * CNTDIV + 1;
  endfunction

  function automatic int frame_busy(input int dut);
    return HALF + (frame_bits(dut) + 1) * CNTDIV + 1;
  endfunction

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int dut, input logic [7:0] d, input logic pbit,
                            input logic stopv, output int t_start);
    logic bits [$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (dut != 0) bits.push_back(pbit);
    bits.push_back(stopv);
    if (dut == 2) bits.push_back(1'b1);
    t_start = cyc;
    foreach (bits[k]) begin
      rxd[dut] = bits[k];
      idle(CNTDIV);
    end
    rxd[dut] = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    idle(5);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({o_data[i], o_valid[i], o_perr[i], o_ferr[i], o_busy[i]} !== 12'h000) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got %h expected 000", i,
                 {o_data[i], o_valid[i], o_perr[i], o_ferr[i], o_busy[i]});
      end
    end
    rstn = 1'b1;
    idle(30);
    checks++;
    if (mon_q.size() != 0) begin
      errors++;
      $display("FAIL reset_idle_strobes: got %0d expected 0", mon_q.size());
    end
    mon_q.delete();
  endtask

  task automatic test_8n1();
    int t, b0;
    rec_t r;
    b0 = busy_cnt[0];
    send_frame(0, 8'hA5, 1'b0, 1'b1, t);
    idle(4);
    checks++;
    if (mon_q.size() != 1) begin
      errors++;
      $display("FAIL 8n1_strobes: got %0d expected 1", mon_q.size());
    end else begin
      r = mon_q.pop_front();
      checks++;
      if ({r.dut[1:0], r.d, r.pe, r.fe} !== {2'd0, 8'hA5, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL 8n1_word: got %h expected %h", {r.dut[1:0], r.d, r.pe, r.fe},
                 {2'd0, 8'hA5, 1'b0, 1'b0});
      end
      checks++;
      if (r.cyc != exp_cyc(0, t)) begin
        errors++;
        $display("FAIL 8n1_strobe_cycle: got %0d expected %0d", r.cyc, exp_cyc(0, t));
      end
    end
    checks++;
    if (busy_cnt[0] - b0 != frame_busy(0)) begin
      errors++;
      $display("FAIL 8n1_busy_cycles: got %0d expected %0d", busy_cnt[0] - b0, frame_busy(0));
    end
    mon_q.delete();
  endtask

  task automatic test_parity();
    int t;
    rec_t r;
    logic pbits [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      send_frame(1, 8'h03, pbits[k], 1'b1, t);
      idle(4);
      checks++;
      if (mon_q.size() != 1) begin
        errors++;
        $display("FAIL parity_strobes pbit=%0d: got %0d expected 1", pbits[k], mon_q.size());
      end else begin
        r = mon_q.pop_front();
        checks++;
        if ({r.dut[1:0], r.d, r.pe, r.fe} !== {2'd1, 8'h03, exp_perr(1, 8'h03, pbits[k]), 1'b0}) begin
          errors++;
          $display("FAIL parity_word pbit=%0d: got %h expected %h", pbits[k],
                   {r.dut[1:0], r.d, r.pe, r.fe}, {2'd1, 8'h03, exp_perr(1, 8'h03, pbits[k]), 1'b0});
        end
        checks++;
        if (r.cyc != exp_cyc(1, t)) begin
          errors++;
          $display("FAIL parity_strobe_cycle: got %0d expected %0d", r.cyc, exp_cyc(1, t));
        end
      end
      mon_q.delete();
    end
  endtask

  task automatic test_frame_err();
    int t;
    rec_t r;
    logic [7:0] words [2] = '{8'h5A, 8'h11};
    logic       stops [2] = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      send_frame(0, words[k], 1'b0, stops[k], t);
      idle(CNTDIV + 4);
      checks++;
      if (mon_q.size() != 1) begin
        errors++;
        $display("FAIL frame_strobes %h: got %0d expected 1", words[k], mon_q.size());
      end else begin
        r = mon_q.pop_front();
        checks++;
        if ({r.dut[1:0], r.d, r.pe, r.fe} !== {2'd0, words[k], 1'b0, ~stops[k]}) begin
          errors++;
          $display("FAIL frame_word: got %h expected %h", {r.dut[1:0], r.d, r.pe, r.fe},
                   {2'd0, words[k], 1'b0, ~stops[k]});
        end
      end
      // Flags must hold between strobes.
      checks++;
      if (o_ferr[0] !== ~stops[k]) begin
        errors++;
        $display("FAIL frame_flag_hold: got %b expected %b", o_ferr[0], ~stops[k]);
      end
      mon_q.delete();
    end
  endtask

  task automatic test_glitch();
    int b0;
    b0 = busy_cnt[0];
    rxd[0] = 1'b0;
    idle(5);
    rxd[0] = 1'b1;
    idle(40);
    checks++;
    if (mon_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_strobes: got %0d expected 0", mon_q.size());
    end
    checks++;
    if (busy_cnt[0] - b0 != HALF + 1) begin
      errors++;
      $display("FAIL glitch_busy_cycles: got %0d expected %0d", busy_cnt[0] - b0, HALF + 1);
    end
    mon_q.delete();
  endtask

  task automatic test_back_to_back();
    int t [2];
    rec_t r;
    logic [7:0] words [2] = '{8'h00, 8'hFF};
    send_frame(2, words[0], good_parity(2, words[0]), 1'b1, t[0]);
    send_frame(2, words[1], good_parity(2, words[1]), 1'b1, t[1]);
    idle(20);
    checks++;
    if (mon_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_strobes: got %0d expected 2", mon_q.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        r = mon_q.pop_front();
        checks++;
        if ({r.dut[1:0], r.d, r.pe, r.fe} !== {2'd2, words[k], 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL b2b_word%0d: got %h expected %h", k, {r.dut[1:0], r.d, r.pe, r.fe},
                   {2'd2, words[k], 1'b0, 1'b0});
        end
        checks++;
        if (r.cyc != exp_cyc(2, t[k])) begin
          errors++;
          $display("FAIL b2b_cycle%0d: got %0d expected %0d", k, r.cyc, exp_cyc(2, t[k]));
        end
      end
    end
    mon_q.delete();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d = 8'hC3;
    int t;
    rec_t r;
    rxd[0] = 1'b0;
    idle(CNTDIV);
    for (int i = 0; i < 3; i++) begin
      rxd[0] = d[i];
      idle(CNTDIV);
    end
    rxd[0] = d[3];
    idle(CNTDIV / 2);
    checks++;
    if (o_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy_before_reset: got %b expected 1", o_busy[0]);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({o_data[0], o_valid[0], o_perr[0], o_ferr[0], o_busy[0]} !== 12'h000) begin
      errors++;
      $display("FAIL midframe_reset_outputs: got %h expected 000",
               {o_data[0], o_valid[0], o_perr[0], o_ferr[0], o_busy[0]});
    end
    idle(3);
    rstn = 1'b1;
    // Line is still low at release and stays low through bits 4..5.
    idle(CNTDIV / 2);
    for (int i = 4; i < 8; i++) begin
      rxd[0] = d[i];
      idle(CNTDIV);
    end
    rxd[0] = 1'b1;
    idle(CNTDIV + 40);
    checks++;
    if (mon_q.size() != 0) begin
      errors++;
      $display("FAIL midframe_strobes: got %0d expected 0", mon_q.size());
    end
    mon_q.delete();
    send_frame(0, 8'h3C, 1'b0, 1'b1, t);
    idle(4);
    checks++;
    if (mon_q.size() != 1) begin
      errors++;
      $display("FAIL after_reset_strobes: got %0d expected 1", mon_q.size());
    end else begin
      r = mon_q.pop_front();
      checks++;
      if ({r.dut[1:0], r.d, r.pe, r.fe} !== {2'd0, 8'h3C, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL after_reset_word: got %h expected %h", {r.dut[1:0], r.d, r.pe, r.fe},
                 {2'd0, 8'h3C, 1'b0, 1'b0});
      end
      checks++;
      if (r.cyc != exp_cyc(0, t)) begin
        errors++;
        $display("FAIL after_reset_cycle: got %0d expected %0d", r.cyc, exp_cyc(0, t));
      end
    end
    mon_q.delete();
  endtask

  task automatic test_random();
    int dut, gap, t;
    logic [7:0] d;
    logic pbit, stopv, epe;
    rec_t r;
    for (int n = 0; n < 30; n++) begin
      dut   = int'($urandom_range(2));
      d     = 8'($urandom);
      pbit  = good_parity(dut, d) ^ ($urandom_range(3) == 0);
      stopv = ($urandom_range(5) != 0);
      epe   = exp_perr(dut, d, pbit);
      gap   = int'($urandom_range(10));
      // After a low single stop bit the line needs a high period before a new fall.
      if (!stopv && dut != 2) gap += CNTDIV;
      send_frame(dut, d, pbit, stopv, t);
      idle(gap);
      checks++;
      if (mon_q.size() != 1) begin
        errors++;
        $display("FAIL rand%0d_strobes dut%0d: got %0d expected 1", n, dut, mon_q.size());
      end else begin
        r = mon_q.pop_front();
        checks++;
        if ({r.dut[1:0], r.d, r.pe, r.fe} !== {2'(dut), d, epe, ~stopv}) begin
          errors++;
          $display("FAIL rand%0d_word: got %h expected %h", n, {r.dut[1:0], r.d, r.pe, r.fe},
                   {2'(dut), d, epe, ~stopv});
        end
        checks++;
        if (r.cyc != exp_cyc(dut, t)) begin
          errors++;
          $display("FAIL rand%0d_cycle: got %0d expected %0d", n, r.cyc, exp_cyc(dut, t));
        end
      end
      mon_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
